// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - two-requester round-robin arbiter for one shared, registered adder
// Each operation walks IDLE -> ISSUE -> WAIT -> DONE; done pulses three cycles after the IDLE sample.
module adder_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state;
  state_t state_nxt;
  logic   sel;
  logic   last;
  logic   pick;
  logic   start;

  // On a tie the requester that was not served last wins.
  always_comb begin
    start = req0 | req1;
    pick  = (req0 & req1) ? ~last : req1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel    <= 1'b0;
      last   <= 1'b1;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      result <= '0;
      add_a  <= '0;
      add_b  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sel   <= pick;
            add_a <= pick ? a1 : a0;
            add_b <= pick ? b1 : b0;
            gnt0  <= ~pick;
            gnt1  <= pick;
          end
        end
        WAIT: begin
          // add_sum reflects the operands the adder captured on the ISSUE edge.
          result <= add_sum;
          done0  <= ~sel;
          done1  <= sel;
        end
        DONE: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          done0 <= 1'b0;
          done1 <= 1'b0;
          last  <= sel;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - self-checking bench for adder_arbiter with a registered shared-adder model
module tb_adder_arbiter;

  logic       clk;
  logic       rst;
  logic       req0;
  logic       req1;
  logic [3:0] a0;
  logic [3:0] b0;
  logic [3:0] a1;
  logic [3:0] b1;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;
  logic [3:0] result;
  logic       busy;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic [3:0] add_sum;

  int checks;
  int failures;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [3:0] a1;
    logic [3:0] b1;
    logic       chg;
    logic [3:0] na0;
    logic       esel;
    logic [3:0] eres;
  } vec_t;

  typedef struct packed {
    logic       sel;
    logic [3:0] res;
  } exp_t;

  vec_t vt[9];
  exp_t sb[$];

  adder_arbiter #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .req0(req0),
    .a0(a0),
    .b0(b0),
    .req1(req1),
    .a1(a1),
    .b1(b1),
    .gnt0(gnt0),
    .gnt1(gnt1),
    .done0(done0),
    .done1(done1),
    .result(result),
    .busy(busy),
    .add_a(add_a),
    .add_b(add_b),
    .add_sum(add_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared adder: registers the sum, one-cycle latency.
  always @(posedge clk) add_sum <= add_a + add_b;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(logic r0, logic r1, logic [3:0] va0, logic [3:0] vb0,
                              logic [3:0] va1, logic [3:0] vb1, logic c, logic [3:0] n,
                              logic es, logic [3:0] er);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.a0 = va0; v.b0 = vb0; v.a1 = va1; v.b1 = vb1;
    v.chg = c; v.na0 = n; v.esel = es; v.eres = er;
    return v;
  endfunction

  // Scoreboard pop and per-cycle invariants.
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_exclusive", int'(gnt0 & gnt1), 0);
      chk("done_exclusive", int'(done0 & done1), 0);
      chk("busy_vs_gnt", int'(busy), int'(gnt0 | gnt1));
      if (done0 | done1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_requester", int'(done1), int'(e.sel));
          chk("result", int'(result), int'(e.res));
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    bit seen;
    @(negedge clk);
    req0 = v.r0; req1 = v.r1;
    a0 = v.a0; b0 = v.b0; a1 = v.a1; b1 = v.b1;
    sb.push_back({v.esel, v.eres});
    seen = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk($sformatf("v%0d_add_a", idx), int'(add_a), int'(v.esel ? v.a1 : v.a0));
        chk($sformatf("v%0d_add_b", idx), int'(add_b), int'(v.esel ? v.b1 : v.b0));
        if (v.chg) a0 = v.na0;
      end
      if (cyc <= 3)
        chk($sformatf("v%0d_gnt", idx), int'({gnt1, gnt0}), v.esel ? 2 : 1);
      if (done0 | done1) begin
        chk($sformatf("v%0d_latency", idx), cyc, 3);
        req0 = 1'b0; req1 = 1'b0;
        seen = 1;
        break;
      end
    end
    if (!seen) chk($sformatf("v%0d_timeout", idx), 0, 1);
  endtask

  initial begin
    int dc[3];
    int nd;
    checks = 0; failures = 0;
    rst = 1'b0; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;

    // Expected results assume the pointer starts at "last served 1".
    vt[0] = mk(1'b1, 1'b0, 4'd3, 4'd4, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7);
    vt[1] = mk(1'b0, 1'b1, 4'd0, 4'd0, 4'd9, 4'd8, 1'b0, 4'd0, 1'b1, 4'd1);
    vt[2] = mk(1'b1, 1'b1, 4'd1, 4'd2, 4'd5, 4'd5, 1'b0, 4'd0, 1'b0, 4'd3);
    vt[3] = mk(1'b1, 1'b1, 4'd7, 4'd7, 4'd15, 4'd15, 1'b0, 4'd0, 1'b1, 4'd14);
    vt[4] = mk(1'b1, 1'b0, 4'd15, 4'd1, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    vt[5] = mk(1'b1, 1'b0, 4'd2, 4'd2, 4'd0, 4'd0, 1'b1, 4'd15, 1'b0, 4'd4);
    vt[6] = mk(1'b1, 1'b1, 4'd0, 4'd0, 4'd6, 4'd3, 1'b0, 4'd0, 1'b1, 4'd9);
    vt[7] = mk(1'b0, 1'b1, 4'd0, 4'd0, 4'd15, 4'd15, 1'b0, 4'd0, 1'b1, 4'd14);
    vt[8] = mk(1'b1, 1'b1, 4'd8, 4'd8, 4'd1, 4'd1, 1'b0, 4'd0, 1'b0, 4'd0);

    #2 rst = 1'b1;
    #1;
    chk("rst_outputs", int'({gnt0, gnt1, done0, done1, busy}), 0);
    chk("rst_data", int'({add_a, add_b, result}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vt[i], i);

    // Idle with no requests holds the adder operands.
    repeat (3) @(negedge clk);
    chk("idle_hold_add_a", int'(add_a), 8);
    chk("idle_hold_add_b", int'(add_b), 8);
    chk("idle_busy", int'(busy), 0);

    // Reset during WAIT discards the operation.
    @(negedge clk);
    req0 = 1'b1; a0 = 4'd5; b0 = 4'd6;
    sb.push_back({1'b0, 4'd11});
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    #1 rst = 1'b1;
    sb.delete();
    #1;
    chk("midop_rst_outputs", int'({gnt0, gnt1, done0, done1, busy}), 0);
    chk("midop_rst_data", int'({add_a, add_b, result}), 0);
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", int'(done0 | done1), 0);
    end

    // Both held from reset: 0 wins, then alternation every four cycles.
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; a0 = 4'd1; b0 = 4'd2; a1 = 4'd5; b1 = 4'd5;
    sb.push_back({1'b0, 4'd3});
    sb.push_back({1'b1, 4'd10});
    sb.push_back({1'b0, 4'd3});
    nd = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      if (done0 | done1) begin
        dc[nd] = cyc;
        nd++;
        if (nd == 3) begin
          req0 = 1'b0; req1 = 1'b0;
          break;
        end
      end
    end
    chk("tie_done_count", nd, 3);
    if (nd == 3) begin
      chk("tie_done_cyc0", dc[0], 3);
      chk("tie_done_cyc1", dc[1], 7);
      chk("tie_done_cyc2", dc[2], 11);
    end else begin
      req0 = 1'b0; req1 = 1'b0;
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
